ram_port_arbiter: RTL and testbench

- Shares one simple dual-port block RAM (write-only port A, read-only port B, 2^AW x DW) between two client requesters.
- Each cycle, a round-robin arbiter accepts at most one command. Writes go to port A; reads go to port B.
- Read data is routed back to the originating client with a fixed latency.
- Sits between client logic and the RAM IP instance; replaces ad-hoc direct drive of the RAM ports.

---
 rtl/ram_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one simple dual-port block RAM (write-only port A,
// read-only port B) between two clients through a round-robin arbiter that
// accepts at most one command per clock. Read data returns to the issuing
// client after a fixed latency of RD_LAT+1 clocks from acceptance.
//
// Optional build macro RAM_ARB_INIT_EN: when defined, an INIT state follows
// reset and zero-fills the whole RAM (one word per clock) before commands
// are accepted; busy is high for that time. When undefined, busy is tied low
// and the arbiter is live straight after reset.
module ram_port_arbiter #(
  parameter int AW     = 9,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c0_req,
  input  logic          c0_we,
  input  logic [AW-1:0] c0_addr,
  input  logic [DW-1:0] c0_wdata,
  output logic          c0_ack,
  output logic          c0_rvalid,
  output logic [DW-1:0] c0_rdata,
  input  logic          c1_req,
  input  logic          c1_we,
  input  logic [AW-1:0] c1_addr,
  input  logic [DW-1:0] c1_wdata,
  output logic          c1_ack,
  output logic          c1_rvalid,
  output logic [DW-1:0] c1_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

`ifdef RAM_ARB_INIT_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_ARB;
`endif

  state_t          state_q, state_d;
  // last_q = 1 means client 1 was granted most recently (client 0 wins a tie)
  logic            last_q, last_d;
  logic            ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_waddr_q, ram_waddr_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
  logic [AW-1:0]   ram_raddr_q, ram_raddr_d;
  // read-return pipe: stage 0 is loaded at acceptance, stage RD_LAT drives rvalid
  logic [RD_LAT:0] vld_q, vld_d;
  logic [RD_LAT:0] tag_q, tag_d;

  logic            grant0, grant1;
  logic            accept, sel, cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;

`ifdef RAM_ARB_INIT_EN
  logic [AW-1:0]   init_addr_q, init_addr_d;
  logic            init_drive;
`endif

  // Round-robin grant; nothing is granted under reset or while initialising
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && (state_q == ST_ARB)) begin
      grant0 = c0_req && (!c1_req || last_q);
      grant1 = c1_req && (!c0_req || !last_q);
    end
  end

  assign c0_ack = grant0;
  assign c1_ack = grant1;

  // Select the command of the granted client
  always_comb begin
    accept    = grant0 | grant1;
    sel       = grant1;
    cmd_we    = grant1 ? c1_we    : c0_we;
    cmd_addr  = grant1 ? c1_addr  : c0_addr;
    cmd_wdata = grant1 ? c1_wdata : c0_wdata;
  end

  // Next-state: INIT sweep, or route the accepted command to the RAM ports
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    ram_we_d    = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    ram_raddr_d = ram_raddr_q;
    vld_d       = {vld_q[RD_LAT-1:0], 1'b0};
    tag_d       = {tag_q[RD_LAT-1:0], sel};
`ifdef RAM_ARB_INIT_EN
    init_addr_d = init_addr_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef RAM_ARB_INIT_EN
        // keep the port-A registers tracking the sweep so they hold the
        // final init address/data once the arbiter takes over
        ram_waddr_d = init_addr_q;
        ram_wdata_d = '0;
        init_addr_d = init_addr_q + AW'(1);
        if (init_addr_q == {AW{1'b1}}) begin
          state_d = ST_ARB;
        end
`else
        state_d = ST_ARB;
`endif
      end
      default: begin
        if (accept) begin
          last_d = sel;
          if (cmd_we) begin
            ram_we_d    = 1'b1;
            ram_waddr_d = cmd_addr;
            ram_wdata_d = cmd_wdata;
          end else begin
            ram_raddr_d = cmd_addr;
            vld_d[0]    = 1'b1;
          end
        end
      end
    endcase
  end

  // Control and RAM-port registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      last_q      <= 1'b1;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      ram_raddr_q <= '0;
      vld_q       <= '0;
`ifdef RAM_ARB_INIT_EN
      init_addr_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      ram_we_q    <= ram_we_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_raddr_q <= ram_raddr_d;
      vld_q       <= vld_d;
`ifdef RAM_ARB_INIT_EN
      init_addr_q <= init_addr_d;
`endif
    end
  end

  // Owner tags are qualified by vld_q, so they need no reset
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

`ifdef RAM_ARB_INIT_EN
  // the sweep drives port A directly so the first zero-write lands in the
  // very first cycle after reset is released
  assign init_drive = (state_q == ST_INIT) && !rst;
  assign busy       = (state_q == ST_INIT);
  assign ram_we     = init_drive | ram_we_q;
  assign ram_waddr  = init_drive ? init_addr_q : ram_waddr_q;
  assign ram_wdata  = init_drive ? '0 : ram_wdata_q;
`else
  assign busy       = 1'b0;
  assign ram_we     = ram_we_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_wdata  = ram_wdata_q;
`endif

  assign ram_raddr = ram_raddr_q;

  assign c0_rvalid = vld_q[RD_LAT] & ~tag_q[RD_LAT];
  assign c1_rvalid = vld_q[RD_LAT] &  tag_q[RD_LAT];
  assign c0_rdata  = ram_rdata;
  assign c1_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: behavioural RAM, reference arbiter model
// and a read-return scoreboard. Honours RAM_ARB_INIT_EN when defined.
module tb_ram_port_arbiter;

  localparam int AW     = 9;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << AW;

`ifdef RAM_ARB_INIT_EN
  localparam bit            INIT_EN = 1'b1;
  localparam logic [DW-1:0] PRELOAD = '1;
`else
  localparam bit            INIT_EN = 1'b0;
  localparam logic [DW-1:0] PRELOAD = '0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          c0_req, c0_we, c1_req, c1_we;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic          c0_ack, c1_ack, c0_rvalid, c1_rvalid;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic          ram_we, busy;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_ack(c0_ack), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_ack(c1_ack), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .busy(busy)
  );

  // behavioural simple dual-port RAM with RD_LAT read latency
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_pipe [RD_LAT];
  logic          mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= PRELOAD;
      mem_loaded <= 1'b1;
    end else if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    rd_pipe[0] <= mem[ram_raddr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RD_LAT-1];

  typedef struct {
    logic          cl;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] shadow [DEPTH];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;
  logic          last_m, init_m;
  int            init_cnt;
  logic          exp_we, exp_rd;
  logic [AW-1:0] exp_waddr, exp_raddr;
  logic [DW-1:0] exp_wdata;
  logic          a0_seen, a1_seen;

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a * 37) ^ 16'hC3A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference model, evaluated once per cycle away from the clock edge
  task automatic monitor();
    exp_t          e;
    logic          ea0, ea1, sel, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a0_seen = c0_ack;
    a1_seen = c1_ack;
    if (!mon_en) return;
    check("busy", 32'(busy), 32'(init_m));
    if (init_m && !rst) begin
      check("init_we", 32'(ram_we), 32'd1);
      check("init_waddr", 32'(ram_waddr), 32'(init_cnt));
      check("init_wdata", 32'(ram_wdata), 32'd0);
      shadow[init_cnt] = '0;
    end else begin
      check("ram_we", 32'(ram_we), 32'(exp_we));
      if (exp_we) begin
        check("ram_waddr", 32'(ram_waddr), 32'(exp_waddr));
        check("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
      end
    end
    if (exp_rd) check("ram_raddr", 32'(ram_raddr), 32'(exp_raddr));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rvalid", 32'({c1_rvalid, c0_rvalid}), e.cl ? 32'd2 : 32'd1);
      check("rdata", 32'(e.cl ? c1_rdata : c0_rdata), 32'(e.data));
    end else begin
      check("rvalid_idle", 32'({c1_rvalid, c0_rvalid}), 32'd0);
    end
    ea0 = !rst && !init_m && c0_req && (!c1_req || last_m);
    ea1 = !rst && !init_m && c1_req && (!c0_req || !last_m);
    check("acks", 32'({c1_ack, c0_ack}), 32'({ea1, ea0}));
    exp_we = 1'b0;
    exp_rd = 1'b0;
    if (rst) begin
      last_m   = 1'b1;
      init_m   = INIT_EN;
      init_cnt = 0;
      sb.delete();
    end else begin
      if (init_m) begin
        init_cnt++;
        if (init_cnt == DEPTH) init_m = 1'b0;
      end
      if (ea0 || ea1) begin
        sel    = ea1;
        w      = sel ? c1_we    : c0_we;
        a      = sel ? c1_addr  : c0_addr;
        d      = sel ? c1_wdata : c0_wdata;
        last_m = sel;
        if (w) begin
          shadow[a] = d;
          exp_we    = 1'b1;
          exp_waddr = a;
          exp_wdata = d;
        end else begin
          e.cl   = sel;
          e.data = shadow[a];
          e.due  = cyc + 1 + RD_LAT;
          sb.push_back(e);
          exp_rd    = 1'b1;
          exp_raddr = a;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy !== 1'b0 && n < DEPTH + 8) begin
      tick();
      n++;
    end
    check("ready_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready();
  endtask

  // both clients hold req until their n commands have been acknowledged
  task automatic run_both(input logic w0, input int base0, input int n0,
                          input logic w1, input int base1, input int n1);
    int i0 = 0;
    int i1 = 0;
    int guard = 0;
    while ((i0 < n0 || i1 < n1) && guard < 2 * (n0 + n1) + 8) begin
      c0_req = (i0 < n0); c0_we = w0; c0_addr = AW'(base0 + i0); c0_wdata = pat(base0 + i0);
      c1_req = (i1 < n1); c1_we = w1; c1_addr = AW'(base1 + i1); c1_wdata = pat(base1 + i1);
      tick();
      if (a0_seen) i0++;
      if (a1_seen) i1++;
      guard++;
    end
    c0_req = 1'b0;
    c1_req = 1'b0;
    check("stream_done", 32'(i0 == n0 && i1 == n1), 32'd1);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < DEPTH; i++) shadow[i] = PRELOAD;
    rst = 1'b1;
    c0_req = 1'b1; c0_we = 1'b1; c0_addr = '0; c0_wdata = '0;
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = '0; c1_wdata = '0;
    a0_seen = 1'b0; a1_seen = 1'b0;
    last_m = 1'b1; init_m = INIT_EN; init_cnt = 0;
    exp_we = 1'b0; exp_rd = 1'b0;
    exp_waddr = '0; exp_raddr = '0; exp_wdata = '0;

    // reset values, with both clients requesting
    tick();
    tick();
    @(negedge clk);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_waddr", 32'(ram_waddr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_ram_raddr", 32'(ram_raddr), 32'd0);
    check("rst_c0_rvalid", 32'(c0_rvalid), 32'd0);
    check("rst_c1_rvalid", 32'(c1_rvalid), 32'd0);
    check("rst_c0_ack", 32'(c0_ack), 32'd0);
    check("rst_c1_ack", 32'(c1_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'(INIT_EN));
    @(posedge clk);
    cyc++;
    #1;
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    c0_req = 1'b0;
    c1_req = 1'b0;
    wait_ready();

    // top address after reset (zero-filled when init is built in)
    run_both(1'b0, DEPTH - 1, 1, 1'b0, 0, 0);
    repeat (3) tick();

    // write then read the same address on the next cycle
    c0_req = 1'b1; c0_we = 1'b1; c0_addr = AW'(5); c0_wdata = 16'hA5A5;
    tick();
    c0_we = 1'b0;
    tick();
    c0_req = 1'b0;
    repeat (4) tick();

    // contended writes alternate, client 0 first after reset
    do_reset();
    run_both(1'b1, 0, 4, 1'b1, 100, 4);
    repeat (2) tick();

    // interleaved back-to-back reads return to the right client in order
    run_both(1'b0, 0, 4, 1'b0, 100, 4);
    run_both(1'b0, 100, 4, 1'b0, 0, 4);
    repeat (4) tick();

    // reset with reads in flight, a write request held through reset
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = AW'(100);
    tick();
    c0_addr = AW'(101);
    tick();
    c0_req = 1'b0;
    rst = 1'b1;
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = AW'(200); c1_wdata = 16'h1234;
    tick();
    rst = 1'b0;
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = AW'(200);
    wait_ready();
    guard = 0;
    while ((c0_req || c1_req) && guard < 8) begin
      tick();
      if (a0_seen) c0_req = 1'b0;
      if (a1_seen) c1_req = 1'b0;
      guard++;
    end
    c0_req = 1'b0;
    c1_req = 1'b0;
    check("tie_done", 32'(guard), 32'd2);
    run_both(1'b0, 200, 1, 1'b0, 0, 0);

    repeat (6) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
